// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, even parity, one stop bit, bit period WORK_FR+1 PCLK cycles.
// Samples near mid-bit from a synchronized line, flags parity/framing errors, and parks in BREAK on a low stop bit.
module uart_rx #(
  parameter int WIDTH = 12
) (
  input  logic             PCLK,
  input  logic             RESET,
  input  logic             RX_I,
  input  logic [WIDTH-1:0] WORK_FR,
  output logic [7:0]       DATA_RX_O,
  output logic             VALID_RX,
  output logic             PARITY_ERR,
  output logic             FRAME_ERR,
  output logic             BUSY_RX
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [2:0]       arm;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] wf_lat;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             start_edge;
  logic             at_sample;
  logic             frame_done;

  // The forced-high synchronizer values after RESET are not a real idle line, so edge
  // detection waits until rx_s and rx_prev both reflect RX_I; a line still low from an
  // aborted frame cannot fake a start edge.
  assign start_edge = arm[2] & rx_prev & ~rx_s;

  // START waits half a bit period; later states wait a full period between samples.
  assign at_sample = (state == START) ? (cnt == ((wf_lat >> 1) - ONE))
                                      : (cnt == wf_lat);

  assign BUSY_RX = (state != IDLE);

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) state_next = START;
      end
      START: begin
        if (at_sample) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (at_sample && (bit_idx == 3'd7)) state_next = PARITY;
      end
      PARITY: begin
        if (at_sample) state_next = STOP;
      end
      STOP: begin
        if (at_sample) begin
          frame_done = 1'b1;
          state_next = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      arm        <= 3'b000;
      cnt        <= '0;
      wf_lat     <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      DATA_RX_O  <= 8'h00;
      VALID_RX   <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      rx_meta  <= RX_I;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      arm      <= {arm[1:0], 1'b1};
      VALID_RX <= frame_done;

      if (state == IDLE) begin
        cnt     <= '0;
        bit_idx <= 3'd0;
        if (start_edge) wf_lat <= WORK_FR;
      end else if ((state == BREAK) || at_sample) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end

      if ((state == DATA) && at_sample) begin
        shreg[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end

      if ((state == PARITY) && at_sample) par_bit <= rx_s;

      // Results are published together, errors included, so a consumer sees one coherent frame.
      if (frame_done) begin
        DATA_RX_O  <= shreg;
        PARITY_ERR <= par_bit ^ (^shreg);
        FRAME_ERR  <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written sequences
// for false start, break, back-to-back frames and reset in mid-frame.
module tb_uart_rx;

  logic        PCLK;
  logic        RESET;
  logic        rx_i;
  logic [11:0] work_fr;
  logic [7:0]  data_rx_o;
  logic        valid_rx;
  logic        parity_err;
  logic        frame_err;
  logic        busy_rx;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int valid_count = 0;
  int wide_pulses = 0;
  int last_valid_cyc = 0;
  logic valid_prev = 1'b0;
  logic [7:0] cap_data[$];
  logic       cap_perr[$];
  logic       cap_ferr[$];

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic [11:0] wf;
    logic [11:0] wf_after;
    logic [7:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[8];

  uart_rx #(.WIDTH(12)) dut (
    .PCLK       (PCLK),
    .RESET      (RESET),
    .RX_I       (rx_i),
    .WORK_FR    (work_fr),
    .DATA_RX_O  (data_rx_o),
    .VALID_RX   (valid_rx),
    .PARITY_ERR (parity_err),
    .FRAME_ERR  (frame_err),
    .BUSY_RX    (busy_rx)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Captures every completed frame and notices pulses longer than one cycle.
  always @(negedge PCLK) begin
    if (valid_rx) begin
      if (valid_prev) wide_pulses++;
      valid_count++;
      last_valid_cyc = cyc;
      cap_data.push_back(data_rx_o);
      cap_perr.push_back(parity_err);
      cap_ferr.push_back(frame_err);
    end
    valid_prev = valid_rx;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Called #1 after a rising edge; each bit lasts t cycles.
  task automatic apply_stimulus(input logic [7:0] data, input logic par, input logic stop,
                                input int t, input logic [11:0] wf_after);
    logic [10:0] bits;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_i = bits[i];
      if (i == 1) work_fr = wf_after;
      wait_cycles(t);
    end
  endtask

  initial begin
    int n0;
    int vc0;
    int lat;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 12'd15, 12'd15, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 12'd15, 12'd15, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 12'd3,  12'd3,  8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 12'd9,  12'd9,  8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 12'd15, 12'd4,  8'h80, 1'b0, 1'b0};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 12'd9,  12'd40, 8'h7E, 1'b1, 1'b0};
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 12'd15, 12'd15, 8'h5A, 1'b0, 1'b1};
    vecs[7] = '{8'h03, 1'b1, 1'b0, 12'd3,  12'd3,  8'h03, 1'b1, 1'b1};

    RESET = 1'b1;
    rx_i = 1'b1;
    work_fr = 12'd15;
    wait_cycles(3);
    RESET = 1'b0;
    wait_cycles(5);
    check_output("reset_data", data_rx_o, 8'h00);
    check_output("reset_valid", valid_rx, 1'b0);
    check_output("reset_perr", parity_err, 1'b0);
    check_output("reset_ferr", frame_err, 1'b0);
    check_output("reset_busy", busy_rx, 1'b0);

    for (int v = 0; v < 8; v++) begin
      work_fr = vecs[v].wf;
      wait_cycles(2);
      vc0 = valid_count;
      n0 = cyc;
      apply_stimulus(vecs[v].data, vecs[v].par, vecs[v].stop, int'(vecs[v].wf) + 1, vecs[v].wf_after);
      rx_i = 1'b1;
      wait_cycles(2 * (int'(vecs[v].wf) + 1) + 5);
      lat = 2 + int'(vecs[v].wf >> 1) + 10 * (int'(vecs[v].wf) + 1) + 1;
      check_output($sformatf("vec%0d_count", v), valid_count - vc0, 1);
      check_output($sformatf("vec%0d_latency", v), last_valid_cyc - n0, lat);
      check_output($sformatf("vec%0d_data", v), cap_data[valid_count-1], vecs[v].exp_data);
      check_output($sformatf("vec%0d_perr", v), cap_perr[valid_count-1], vecs[v].exp_perr);
      check_output($sformatf("vec%0d_ferr", v), cap_ferr[valid_count-1], vecs[v].exp_ferr);
      check_output($sformatf("vec%0d_busy", v), busy_rx, 1'b0);
    end

    // False start: a 3-cycle glitch must be rejected at the half-bit check.
    work_fr = 12'd15;
    wait_cycles(5);
    vc0 = valid_count;
    rx_i = 1'b0;
    wait_cycles(3);
    rx_i = 1'b1;
    wait_cycles(1);
    check_output("glitch_busy_start", busy_rx, 1'b1);
    wait_cycles(6);
    check_output("glitch_busy_idle", busy_rx, 1'b0);
    wait_cycles(200);
    check_output("glitch_no_valid", valid_count - vc0, 0);

    // Break: low stop bit, line held low 40 more cycles, then released.
    vc0 = valid_count;
    apply_stimulus(8'h3C, 1'b0, 1'b0, 16, 12'd15);
    wait_cycles(40);
    check_output("break_busy_low_line", busy_rx, 1'b1);
    check_output("break_count", valid_count - vc0, 1);
    check_output("break_data", data_rx_o, 8'h3C);
    check_output("break_ferr", frame_err, 1'b1);
    check_output("break_perr", parity_err, 1'b0);
    rx_i = 1'b1;
    wait_cycles(5);
    check_output("break_busy_released", busy_rx, 1'b0);
    wait_cycles(200);
    check_output("break_no_second", valid_count - vc0, 1);

    // Back-to-back frames with no idle gap.
    vc0 = valid_count;
    apply_stimulus(8'h55, 1'b0, 1'b1, 16, 12'd15);
    apply_stimulus(8'hFF, 1'b0, 1'b1, 16, 12'd15);
    wait_cycles(20);
    check_output("b2b_count", valid_count - vc0, 2);
    if (valid_count - vc0 == 2) begin
      check_output("b2b_data0", cap_data[vc0], 8'h55);
      check_output("b2b_data1", cap_data[vc0+1], 8'hFF);
      check_output("b2b_err0", {cap_perr[vc0], cap_ferr[vc0]}, 2'b00);
      check_output("b2b_err1", {cap_perr[vc0+1], cap_ferr[vc0+1]}, 2'b00);
    end

    // Reset during data bit 4 of 0x0F while the line is low; the tail must not look like a start.
    vc0 = valid_count;
    rx_i = 1'b0;
    wait_cycles(16);
    rx_i = 1'b1;
    wait_cycles(64);
    rx_i = 1'b0;
    wait_cycles(8);
    RESET = 1'b1;
    wait_cycles(2);
    RESET = 1'b0;
    wait_cycles(1);
    check_output("rst_mid_busy", busy_rx, 1'b0);
    check_output("rst_mid_data", data_rx_o, 8'h00);
    check_output("rst_mid_errs", {parity_err, frame_err}, 2'b00);
    wait_cycles(20);
    check_output("rst_mid_no_restart", busy_rx, 1'b0);
    wait_cycles(45);
    rx_i = 1'b1;
    wait_cycles(40);
    apply_stimulus(8'h80, 1'b1, 1'b1, 16, 12'd15);
    wait_cycles(20);
    check_output("rst_mid_count", valid_count - vc0, 1);
    check_output("rst_mid_new_data", data_rx_o, 8'h80);
    check_output("rst_mid_new_perr", parity_err, 1'b0);
    check_output("rst_mid_new_ferr", frame_err, 1'b0);

    check_output("valid_one_cycle", wide_pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter WIDTH, default 12, bit-period counter width.
REQ-002 SHALL provide PCLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide RX_I  input  1  asynchronous serial line, idle high.
REQ-005 SHALL provide WORK_FR  input  12  bit period minus one, in PCLK cycles (T = WORK_FR+1).
REQ-006 SHALL provide DATA_RX_O  output  8  last received byte, LSB = first data bit.
REQ-007 SHALL provide VALID_RX  output  1  one-cycle pulse when a frame completes.
REQ-008 SHALL provide PARITY_ERR  output  1  even-parity mismatch on the last frame.
REQ-009 SHALL provide FRAME_ERR  output  1  stop bit sampled low on the last frame.
REQ-010 SHALL provide BUSY_RX  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL accept frame format: start(0), 8 data bits LSB first, parity bit equal to XOR of the 8 data bits, stop(1).
REQ-012 SHALL pass RX_I through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-014 IDLE: a start edge (rx_s low, previous rx_s high) in cycle c0 SHALL move to START, clear the counter, and latch WORK_FR for the whole frame.
REQ-015 START: at c0+(WORK_FR>>1), if rx_s=1 it SHALL be treated as a false start and return to IDLE without VALID_RX; otherwise it SHALL go to DATA with bit index 0.
REQ-016 Data bit k (k=0..7) SHALL be sampled at c0+(WORK_FR>>1)+(k+1)*T into bit k of the shift register; DATA SHALL exit to PARITY after k=7.
REQ-017 The parity bit SHALL be sampled at c0+(WORK_FR>>1)+9*T, and the stop bit at c0+(WORK_FR>>1)+10*T.
REQ-018 The counter SHALL count 0..latched WORK_FR, then wrap to 0 on each sample point; it SHALL be WIDTH bits wide, with no overflow for WORK_FR < 2^WIDTH.
REQ-019 In the cycle after the stop sample, the block SHALL update DATA_RX_O, PARITY_ERR and FRAME_ERR together and pulse VALID_RX for exactly 1 cycle, even when errors are present.
REQ-020 DATA_RX_O, PARITY_ERR and FRAME_ERR SHALL hold their values until the next VALID_RX.
REQ-021 If stop=1, the block SHALL go to IDLE in the cycle after the stop sample and SHALL accept a new start edge from that cycle (back-to-back frames).
REQ-022 If stop=0, the block SHALL go to BREAK and remain there until rx_s=1, then go to IDLE; no start edge is detected while in BREAK.
REQ-023 WORK_FR changes during a frame SHALL NOT affect that frame.
REQ-024 The supported range SHALL be WORK_FR >= 3; behaviour for WORK_FR < 3 is unspecified.
REQ-025 No input SHALL abort a frame except RESET.

Reset
REQ-026 RESET SHALL force state IDLE, counter 0, bit index 0, shift register 0, DATA_RX_O=8'h00, VALID_RX=0, PARITY_ERR=0, FRAME_ERR=0, BUSY_RX=0, and both synchronizer flops to 1.
REQ-027 RESET mid-frame SHALL discard the partial frame with no VALID_RX, and reception SHALL restart only on a fresh start edge after RESET deasserts.

Verification
REQ-028 WORK_FR=15, send 0xA5 with parity 0, stop 1 -> one VALID_RX pulse, DATA_RX_O=8'hA5, PARITY_ERR=0, FRAME_ERR=0, VALID_RX exactly 1 cycle after the stop sample (c0+167 relative to synchronized edge).
REQ-029 WORK_FR=15, send 0x01 with parity 0 -> DATA_RX_O=8'h01, PARITY_ERR=1, FRAME_ERR=0.
REQ-030 WORK_FR=15, send 0x3C with stop bit 0, line held low 40 further cycles then high -> FRAME_ERR=1, BUSY_RX stays high until the line returns high, and no second VALID_RX.
REQ-031 WORK_FR=15, 3-cycle low glitch on RX_I -> no VALID_RX, BUSY_RX returns low by c0+8.
REQ-032 WORK_FR=15, frames 0x55 and 0xFF sent back-to-back (next start immediately after stop) -> two VALID_RX pulses, with values 8'h55 then 8'hFF and no errors.
REQ-033 RESET asserted during data bit 4, then 0x80 sent -> only one VALID_RX pulse, with DATA_RX_O=8'h80 and PARITY_ERR=0 for parity 1.
